// File: rtl/rv32i_types.sv
// RV32I shared types: the RVFI retirement record carried alongside each instruction.
package rv32i_types;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_word;

endpackage

// File: rtl/tomasula_types.sv
// Tomasulo front-end types: decoded control word, issue-queue entry and lane prefix count.
package tomasula_types;

    localparam int unsigned MAX_LANES = 4;

    typedef enum logic [2:0] {
        FU_ALU,
        FU_MUL,
        FU_BR,
        FU_LD,
        FU_ST,
        FU_JMP
    } fu_t;

    typedef struct packed {
        fu_t         fu;
        logic [3:0]  aluop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [31:0] imm;
        logic [31:0] pc;
    } ctl_word;

    typedef struct packed {
        ctl_word              ctl;
        rv32i_types::rvfi_word rvfi;
    } iq_entry_t;

    // Length of the unbroken run of set bits starting at bit 0.
    function automatic logic [2:0] prefix_count(input logic [MAX_LANES-1:0] v);
        logic [2:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (run && v[i]) begin
                n = n + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: multi-lane enqueue from decode, single-entry dequeue to the
// reservation stations, with mispredict flush.
module dispatch_queue
    import tomasula_types::*;
#(
    parameter int unsigned WIDTH_IN = 2,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [WIDTH_IN-1:0]                   enq_valid,
    input  ctl_word [WIDTH_IN-1:0]                enq_ctl,
    input  rv32i_types::rvfi_word [WIDTH_IN-1:0]  enq_rvfi,
    output logic                                  enq_ready,
    output logic                                  ack_o,
    input  logic                                  deq_ready,
    output logic                                  deq_valid,
    output ctl_word                               deq_ctl,
    output rv32i_types::rvfi_word                 deq_rvfi,
    output logic [$clog2(DEPTH+1)-1:0]            count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ack_q, ack_d;
    logic [CW-1:0]        free_slots;
    logic [CW-1:0]        accepted;
    logic                 do_deq;
    logic [MAX_LANES-1:0] valid_ext;

    iq_entry_t mem_q [DEPTH];

    // Readiness looks only at the registered count; a dequeue in the same cycle gives no credit.
    always_comb begin
        valid_ext                 = '0;
        valid_ext[WIDTH_IN-1:0]   = enq_valid;
        free_slots                = CW'(DEPTH) - count_q;
        enq_ready                 = free_slots >= CW'(WIDTH_IN);
        accepted                  = enq_ready ? CW'(prefix_count(valid_ext)) : '0;
        deq_valid                 = count_q != '0;
        do_deq                    = deq_valid && deq_ready;

        head_d  = head_q + PW'(do_deq);
        tail_d  = tail_q + PW'(accepted);
        count_d = count_q + accepted - CW'(do_deq);
        ack_d   = accepted != '0;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ack_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ack_q   <= ack_d;
        end
    end

    // Storage is deliberately unreset; count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int unsigned i = 0; i < WIDTH_IN; i++) begin
                if (CW'(i) < accepted) begin
                    mem_q[tail_q + PW'(i)] <= '{ctl: enq_ctl[i], rvfi: enq_rvfi[i]};
                end
            end
        end
    end

    assign deq_ctl  = mem_q[head_q].ctl;
    assign deq_rvfi = mem_q[head_q].rvfi;
    assign count    = count_q;
    assign ack_o    = ack_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CW'(DEPTH));
            assert (!(do_deq && count_q == '0));
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue (WIDTH_IN=2, DEPTH=8): accepted lanes are queued
// in program order and matched against the head on every dequeue.
module tb_dispatch_queue;
    import tomasula_types::*;
    import rv32i_types::*;

    localparam int unsigned W = 2;
    localparam int unsigned D = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [W-1:0]         enq_valid;
    ctl_word [W-1:0]      enq_ctl;
    rvfi_word [W-1:0]     enq_rvfi;
    logic                 enq_ready;
    logic                 ack_o;
    logic                 deq_ready;
    logic                 deq_valid;
    ctl_word              deq_ctl;
    rvfi_word             deq_rvfi;
    logic [3:0]           count;

    int                   checks = 0;
    int                   errors = 0;
    iq_entry_t            sb[$];
    int unsigned          m_count = 0;
    logic                 m_ack = 1'b0;
    int unsigned          seq = 0;
    int unsigned          n_accepted = 0;

    dispatch_queue #(.WIDTH_IN(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ctl   (enq_ctl),
        .enq_rvfi  (enq_rvfi),
        .enq_ready (enq_ready),
        .ack_o     (ack_o),
        .deq_ready (deq_ready),
        .deq_valid (deq_valid),
        .deq_ctl   (deq_ctl),
        .deq_rvfi  (deq_rvfi),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic iq_entry_t make_entry(input int unsigned s);
        iq_entry_t e;
        e.ctl.fu         = fu_t'(3'(s % 6));
        e.ctl.aluop      = 4'(s);
        e.ctl.rd         = 5'(s);
        e.ctl.rs1        = 5'(s + 1);
        e.ctl.rs2        = 5'(s + 2);
        e.ctl.use_imm    = s[0];
        e.ctl.imm        = 32'(s * 7 + 3);
        e.ctl.pc         = 32'h1000 + 32'(s * 4);
        e.rvfi.order     = 64'(s);
        e.rvfi.insn      = 32'(s) ^ 32'hdead_0013;
        e.rvfi.rs1_addr  = 5'(s + 1);
        e.rvfi.rs2_addr  = 5'(s + 2);
        e.rvfi.rd_addr   = 5'(s);
        e.rvfi.pc_rdata  = 32'h1000 + 32'(s * 4);
        e.rvfi.pc_wdata  = 32'h1004 + 32'(s * 4);
        return e;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_count"},     256'(count),     256'(0));
        check({pfx, "_deq_valid"}, 256'(deq_valid), 256'(0));
        check({pfx, "_enq_ready"}, 256'(enq_ready), 256'(1));
        check({pfx, "_ack_o"},     256'(ack_o),     256'(0));
    endtask

    // Entered at a falling edge; drives one cycle of stimulus and advances the model across the rising edge.
    task automatic cycle(input logic [1:0] v, input logic dr, input logic fl);
        iq_entry_t   e [2];
        iq_entry_t   h;
        int unsigned acc;
        logic        ready_exp;
        logic        deq_exp;
        for (int i = 0; i < 2; i++) begin
            e[i]        = make_entry(seq + i);
            enq_ctl[i]  = e[i].ctl;
            enq_rvfi[i] = e[i].rvfi;
        end
        enq_valid = v;
        deq_ready = dr;
        flush     = fl;
        #1;
        ready_exp = (D - m_count) >= W;
        check("count",     256'(count),     256'(m_count));
        check("deq_valid", 256'(deq_valid), 256'(m_count != 0));
        check("enq_ready", 256'(enq_ready), 256'(ready_exp));
        check("ack_o",     256'(ack_o),     256'(m_ack));
        acc = 0;
        if (ready_exp && v[0]) acc = v[1] ? 2 : 1;
        deq_exp = (m_count != 0) && dr;
        if (deq_exp) begin
            h = sb.pop_front();
            check("deq_ctl",  256'(deq_ctl),  256'(h.ctl));
            check("deq_rvfi", 256'(deq_rvfi), 256'(h.rvfi));
        end
        if (fl) begin
            sb.delete();
            m_count = 0;
            m_ack   = 1'b0;
        end else begin
            for (int unsigned i = 0; i < acc; i++) sb.push_back(e[i]);
            m_count    = m_count + acc - (deq_exp ? 1 : 0);
            m_ack      = acc != 0;
            n_accepted = n_accepted + acc;
        end
        seq = seq + 2;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        enq_valid = '0;
        deq_ready = 1'b0;
        enq_ctl   = '0;
        enq_rvfi  = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Fill in 2-lane bursts until full; the burst at count=8 must be ignored.
        repeat (5) cycle(2'b11, 1'b0, 1'b0);
        repeat (8) cycle(2'b00, 1'b1, 1'b0);

        // Non-contiguous lanes: 2'b10 accepts nothing, 2'b01 accepts one.
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);

        // count=7 leaves one slot: enqueue refused while the dequeue still happens.
        repeat (3) cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        repeat (7) cycle(2'b00, 1'b1, 1'b0);

        // Streaming across pointer wrap.
        n_accepted = 0;
        for (int g = 0; g < 100 && n_accepted < 20; g++) cycle(2'b11, 1'b1, 1'b0);
        repeat (12) cycle(2'b00, 1'b1, 1'b0);

        // Flush with concurrent enqueue and dequeue at count=5.
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b1);
        cycle(2'b00, 1'b1, 1'b0);

        repeat (300) cycle(2'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);

        // Asynchronous reset in the middle of a burst, between clock edges.
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        enq_valid = 2'b11;
        deq_ready = 1'b1;
        flush     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_count = 0;
        m_ack   = 1'b0;
        repeat (2) cycle(2'b11, 1'b0, 1'b0);
        repeat (6) cycle(2'b00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
